// File: rtl/eff_flanger_fb_if.sv
// Sample/config bundle for eff_flanger_fb.
// master: drives config, data_i and vld_i; sees data_o, vld_o, busy and ovr.
// slave : the flanger itself.
// en enables the effect (0 = bypass), rate is the LFO increment, base is the minimum delay
// in Q(AW).FRAC_WIDTH samples, sweep is the peak extra delay, fb is the Q1.7 feedback gain
// and mix is the wet amount (0 = dry).
interface eff_flanger_fb_if #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned FRAC_WIDTH = 8
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic                       en;
   logic [15:0]                rate;
   logic [AW+FRAC_WIDTH-1:0]   base;
   logic [AW-1:0]              sweep;
   logic [7:0]                 fb;
   logic [7:0]                 mix;
   logic [DATA_WIDTH-1:0]      data_i;
   logic                       vld_i;
   logic [DATA_WIDTH-1:0]      data_o;
   logic                       vld_o;
   logic                       busy;
   logic                       ovr;

   modport master (
      output en, rate, base, sweep, fb, mix, data_i, vld_i,
      input  data_o, vld_o, busy, ovr
   );

   modport slave (
      input  en, rate, base, sweep, fb, mix, data_i, vld_i,
      output data_o, vld_o, busy, ovr
   );
endinterface

// File: rtl/eff_flanger_fb.sv
// Feedback flanger: LFO-swept fractional delay with linear interpolation, signed feedback
// and wet/dry mix. It owns a circular delay RAM that is zeroed after every reset. Each
// accepted sample runs through IDLE -> RD0 -> RD1 -> CALC -> WR. The result is strobed
// five cycles after acceptance.
// Ports: clk, rst_n (async, active low), bus (eff_flanger_fb_if.slave: config, data_i/vld_i
// in; data_o/vld_o, busy, ovr out).
module eff_flanger_fb #(
   parameter int unsigned DATA_WIDTH  = 24,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned FRAC_WIDTH  = 8,
   parameter int unsigned PHASE_WIDTH = 24
) (
   input logic             clk,
   input logic             rst_n,
   eff_flanger_fb_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned FW = FRAC_WIDTH;
   localparam int unsigned PW = PHASE_WIDTH;
   // Wide enough for x*256 + y*256 without overflow.
   localparam int unsigned WW = DW + 12;
   localparam logic [AW:0] DiMax = (AW+1)'(DEPTH - 2);

   typedef enum logic [2:0] {StClr, StIdle, StRd0, StRd1, StCalc, StWr} state_e;

   state_e                 state_q, state_d;
   logic [AW-1:0]          clr_q, clr_d;
   logic [AW-1:0]          wp_q, wp_d;
   logic [PW-1:0]          phase_q, phase_d;
   logic signed [DW-1:0]   x_q, x_d;
   logic                   en_q, en_d;
   logic [15:0]            rate_q, rate_d;
   logic [AW+FW-1:0]       base_q, base_d;
   logic [AW-1:0]          sweep_q, sweep_d;
   logic [7:0]             fb_q, fb_d;
   logic [7:0]             mix_q, mix_d;
   logic signed [DW-1:0]   x0_q, x0_d;
   logic signed [DW-1:0]   x1_q, x1_d;
   logic signed [DW-1:0]   w_q, w_d;
   logic signed [DW-1:0]   o_q, o_d;
   logic [DW-1:0]          data_o_q, data_o_d;
   logic                   vld_o_q, vld_o_d;
   logic                   ovr_q, ovr_d;

   logic [DW-1:0]          mem_q [DEPTH];
   logic                   mem_we;
   logic [AW-1:0]          mem_waddr;
   logic [DW-1:0]          mem_wdata;
   logic [AW-1:0]          rd_addr;
   logic [DW-1:0]          rd_data;

   function automatic logic signed [DW-1:0] sat(input logic signed [WW-1:0] v);
      if (v[WW-1:DW-1] == {(WW-DW+1){v[WW-1]}}) begin
         return v[DW-1:0];
      end else if (v[WW-1]) begin
         return {1'b1, {(DW-1){1'b0}}};
      end else begin
         return {1'b0, {(DW-1){1'b1}}};
      end
   endfunction

   function automatic logic signed [WW-1:0] sx(input logic signed [DW-1:0] v);
      return {{(WW-DW){v[DW-1]}}, v};
   endfunction

   // LFO triangle and delay split into integer/fraction.
   logic [PW-2:0]    tri_t;
   logic [AW+PW-2:0] sw_prod;
   logic [AW+FW:0]   d_full;
   logic [AW:0]      di_raw;
   logic [AW-1:0]    di;
   logic [FW-1:0]    df;
   logic             unused_sw;

   always_comb begin
      tri_t   = phase_q[PW-1] ? ~phase_q[PW-2:0] : phase_q[PW-2:0];
      sw_prod = (AW+PW-1)'(sweep_q) * (AW+PW-1)'(tri_t);
      // Keeping the top AW+FW bits is the >> (PW-1-FW) rescale into Q(AW).FW.
      d_full  = {1'b0, base_q} + {1'b0, sw_prod[AW+PW-2 -: AW+FW]};
      di_raw  = d_full[AW+FW:FW];
      if (di_raw > DiMax) begin
         di = DiMax[AW-1:0];
         df = '0;
      end else begin
         di = di_raw[AW-1:0];
         df = d_full[FW-1:0];
      end
   end

   assign unused_sw = ^sw_prod[PW-FW-2:0];

   // Tap addresses: RD1 fetches one sample further back than RD0.
   assign rd_addr = (state_q == StRd1) ? (wp_q - AW'(2) - di) : (wp_q - AW'(1) - di);
   assign rd_data = mem_q[rd_addr];

   // Sample arithmetic, all in a wide signed domain, saturated on the way out.
   logic signed [WW-1:0] x_w, x0_w, x1_w, df_w, interp_w, y_w, fb_w, wet_w, dry_w;
   logic signed [DW-1:0] y_s, w_wet, o_wet;

   always_comb begin
      x_w      = sx(x_q);
      x0_w     = sx(x0_q);
      x1_w     = sx(x1_q);
      df_w     = {{(WW-FW){1'b0}}, df};
      interp_w = ((x1_w - x0_w) * df_w) >>> FW;
      y_s      = sat(x0_w + interp_w);
      y_w      = sx(y_s);
      fb_w     = {{(WW-8){fb_q[7]}}, fb_q};
      w_wet    = sat(x_w + ((y_w * fb_w) >>> 7));
      wet_w    = {{(WW-8){1'b0}}, mix_q};
      dry_w    = {{(WW-9){1'b0}}, 9'd256} - wet_w;
      o_wet    = sat(((x_w * dry_w) + (y_w * wet_w)) >>> 8);
   end

   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      wp_d      = wp_q;
      phase_d   = phase_q;
      x_d       = x_q;
      en_d      = en_q;
      rate_d    = rate_q;
      base_d    = base_q;
      sweep_d   = sweep_q;
      fb_d      = fb_q;
      mix_d     = mix_q;
      x0_d      = x0_q;
      x1_d      = x1_q;
      w_d       = w_q;
      o_d       = o_q;
      data_o_d  = data_o_q;
      vld_o_d   = 1'b0;
      ovr_d     = ovr_q | (bus.vld_i & (state_q != StIdle));
      mem_we    = 1'b0;
      mem_waddr = wp_q;
      mem_wdata = w_q;

      case (state_q)
         StClr: begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
            mem_wdata = '0;
            clr_d     = clr_q + AW'(1);
            if (clr_q == AW'(DEPTH - 1)) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (bus.vld_i) begin
               x_d     = bus.data_i;
               en_d    = bus.en;
               rate_d  = bus.rate;
               base_d  = bus.base;
               sweep_d = bus.sweep;
               fb_d    = bus.fb;
               mix_d   = bus.mix;
               state_d = StRd0;
            end
         end
         StRd0: begin
            x0_d    = rd_data;
            state_d = StRd1;
         end
         StRd1: begin
            x1_d    = rd_data;
            state_d = StCalc;
         end
         StCalc: begin
            // Bypass still writes the dry sample so history stays continuous.
            w_d     = en_q ? w_wet : x_q;
            o_d     = en_q ? o_wet : x_q;
            state_d = StWr;
         end
         StWr: begin
            mem_we   = 1'b1;
            wp_d     = wp_q + AW'(1);
            phase_d  = en_q ? (phase_q + PW'(rate_q)) : phase_q;
            data_o_d = o_q;
            vld_o_d  = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StClr;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StClr;
         clr_q    <= '0;
         wp_q     <= '0;
         phase_q  <= '0;
         x_q      <= '0;
         en_q     <= 1'b0;
         rate_q   <= '0;
         base_q   <= '0;
         sweep_q  <= '0;
         fb_q     <= '0;
         mix_q    <= '0;
         x0_q     <= '0;
         x1_q     <= '0;
         w_q      <= '0;
         o_q      <= '0;
         data_o_q <= '0;
         vld_o_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         clr_q    <= clr_d;
         wp_q     <= wp_d;
         phase_q  <= phase_d;
         x_q      <= x_d;
         en_q     <= en_d;
         rate_q   <= rate_d;
         base_q   <= base_d;
         sweep_q  <= sweep_d;
         fb_q     <= fb_d;
         mix_q    <= mix_d;
         x0_q     <= x0_d;
         x1_q     <= x1_d;
         w_q      <= w_d;
         o_q      <= o_d;
         data_o_q <= data_o_d;
         vld_o_q  <= vld_o_d;
         ovr_q    <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.data_o = data_o_q;
   assign bus.vld_o  = vld_o_q;
   assign bus.busy   = (state_q != StIdle);
   assign bus.ovr    = ovr_q;
endmodule

// File: tb/tb_eff_flanger_fb.sv
module tb_eff_flanger_fb;
   localparam int DW    = 24;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int FW    = 8;
   localparam int PW    = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              cfg_en = 1'b0;
   logic [15:0]       cfg_rate = '0;
   logic [AW+FW-1:0]  cfg_base = '0;
   logic [AW-1:0]     cfg_sweep = '0;
   logic [7:0]        cfg_fb = '0;
   logic [7:0]        cfg_mix = '0;
   logic [DW-1:0]     din = '0;
   logic              vld = 1'b0;

   eff_flanger_fb_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAC_WIDTH(FW)) bus ();

   assign bus.en     = cfg_en;
   assign bus.rate   = cfg_rate;
   assign bus.base   = cfg_base;
   assign bus.sweep  = cfg_sweep;
   assign bus.fb     = cfg_fb;
   assign bus.mix    = cfg_mix;
   assign bus.data_i = din;
   assign bus.vld_i  = vld;

   eff_flanger_fb #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAC_WIDTH(FW), .PHASE_WIDTH(PW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: delay line as a plain array, pointer and LFO phase as integers.
   longint m_ram [DEPTH];
   longint m_wp;
   longint m_phase;

   function automatic longint sat24(input longint v);
      if (v > 64'sd8388607) return 64'sd8388607;
      if (v < -64'sd8388608) return -64'sd8388608;
      return v;
   endfunction

   function automatic int wrap(input longint a);
      return int'(((a % DEPTH) + DEPTH) % DEPTH);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_ram[i] = 0;
      m_wp = 0;
      m_phase = 0;
   endtask

   task automatic model_step(input logic [DW-1:0] xin, output longint o);
      longint x, half, low, t, d, di, df, x0, x1, y, w, fbv, mixv;
      x    = longint'($signed(xin));
      fbv  = longint'($signed(cfg_fb));
      mixv = longint'(cfg_mix);
      if (cfg_en) begin
         half = longint'(1) << (PW - 1);
         low  = m_phase % half;
         t    = (m_phase >= half) ? (half - 1 - low) : low;
         d    = longint'(cfg_base) + ((longint'(cfg_sweep) * t) >> (PW - 1 - FW));
         di   = d / 256;
         df   = d % 256;
         if (di > DEPTH - 2) begin
            di = DEPTH - 2;
            df = 0;
         end
         x0 = m_ram[wrap(m_wp - 1 - di)];
         x1 = m_ram[wrap(m_wp - 2 - di)];
         y  = sat24(x0 + (((x1 - x0) * df) >>> FW));
         w  = sat24(x + ((y * fbv) >>> 7));
         o  = sat24((x * (256 - mixv) + y * mixv) >>> 8);
         m_phase = (m_phase + longint'(cfg_rate)) % (longint'(1) << PW);
      end else begin
         w = x;
         o = x;
      end
      m_ram[wrap(m_wp)] = w;
      m_wp = wrap(m_wp + 1);
   endtask

   // Send one sample once idle; checks the N+5 strobe and the modelled result.
   task automatic run_sample(input logic [DW-1:0] x, output logic [DW-1:0] got);
      int k;
      longint eo;
      logic [DW-1:0] expv;
      k = 0;
      while (bus.busy && k < 4 * DEPTH + 20) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (bus.busy) begin
         errors++;
         $display("FAIL idle_wait: busy=%b required 0", bus.busy);
      end
      din = x;
      vld = 1'b1;
      model_step(x, eo);
      expv = eo[DW-1:0];
      @(negedge clk);
      vld = 1'b0;
      k = 1;
      while (!bus.vld_o && k < 12) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k !== 5) begin
         errors++;
         $display("FAIL latency: vld_o after %0d cycles required 5", k);
      end
      got = bus.data_o;
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL data: x=%h got %h required %h", x, got, expv);
      end
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      while (bus.busy && n < 4 * DEPTH) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_reset();
      int n;
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_clear(n);
      checks++;
      if (n !== DEPTH) begin
         errors++;
         $display("FAIL clear_len: busy for %0d cycles required %0d", n, DEPTH);
      end
   endtask

   task automatic set_cfg(input logic e, input logic [15:0] r, input logic [AW+FW-1:0] b,
                          input logic [AW-1:0] s, input logic [7:0] f, input logic [7:0] m);
      cfg_en = e; cfg_rate = r; cfg_base = b; cfg_sweep = s; cfg_fb = f; cfg_mix = m;
   endtask

   task automatic test_reset();
      int n;
      model_reset();
      repeat (3) @(negedge clk);
      checks += 4;
      if (bus.data_o !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", bus.data_o); end
      if (bus.vld_o !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b required 0", bus.vld_o); end
      if (bus.ovr !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b required 0", bus.ovr); end
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b required 1", bus.busy); end
      rst_n = 1'b1;
      wait_clear(n);
      checks += 2;
      if (n !== DEPTH) begin errors++; $display("FAIL busy_len: got %0d required %0d", n, DEPTH); end
      if (bus.ovr !== 1'b0) begin errors++; $display("FAIL clr_ovr: got %b required 0", bus.ovr); end
   endtask

   task automatic test_reset_clear();
      logic [DW-1:0] got;
      set_cfg(1'b0, 16'd0, '0, '0, 8'd0, 8'd0);
      for (int i = 0; i < DEPTH; i++) run_sample(DW'($urandom_range(1, 24'hFFFFFF)), got);
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         set_cfg(1'b1, 16'd0, (AW+FW)'($urandom_range(0, (DEPTH - 1) * 256)), '0, 8'd0, 8'd255);
         run_sample('0, got);
         checks++;
         if (got !== '0) begin errors++; $display("FAIL cleared_tap: got %h required 0", got); end
      end
   endtask

   task automatic test_fixed_delay();
      logic [DW-1:0] got, want;
      do_reset();
      set_cfg(1'b1, 16'd0, (AW+FW)'(3 * 256), '0, 8'd0, 8'd255);
      for (int i = 0; i < 10; i++) begin
         run_sample((i == 0) ? 24'h100000 : 24'h0, got);
         want = (i == 0) ? 24'h001000 : (i == 4) ? 24'h0FF000 : 24'h0;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL fixed_delay[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_fractional();
      logic [DW-1:0] got;
      do_reset();
      set_cfg(1'b1, 16'd0, (AW+FW)'(16'h0280), '0, 8'd0, 8'd255);
      for (int i = 0; i < 8; i++) begin
         run_sample(24'h100000, got);
         if (i == 3) begin
            checks++;
            if (got !== 24'h080800) begin errors++; $display("FAIL frac_mid: got %h required 080800", got); end
         end
         if (i == 7) begin
            checks++;
            if (got !== 24'h100000) begin errors++; $display("FAIL frac_settle: got %h required 100000", got); end
         end
      end
   endtask

   task automatic test_feedback_sat();
      logic [DW-1:0] got;
      do_reset();
      set_cfg(1'b1, 16'd0, '0, '0, 8'd127, 8'd255);
      for (int i = 0; i < 10; i++) begin
         run_sample(24'h7FFFFF, got);
         checks++;
         if (got[DW-1] !== 1'b0) begin errors++; $display("FAIL fb_sign[%0d]: got %h required positive", i, got); end
      end
      checks++;
      if (got !== 24'h7FFFFF) begin errors++; $display("FAIL fb_clamp: got %h required 7fffff", got); end
      cfg_fb = 8'h80;
      for (int i = 0; i < 8; i++) run_sample(24'h400000, got);
   endtask

   task automatic test_overrun_bypass();
      int n, pulses, first;
      longint eo;
      logic [DW-1:0] got, seen;
      // Strobe during CLR is dropped but flagged.
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vld = 1'b1;
      din = 24'h5A5A5A;
      @(negedge clk);
      vld = 1'b0;
      wait_clear(n);
      checks += 2;
      if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovr_clr: got %b required 1", bus.ovr); end
      if (n !== DEPTH - 2) begin errors++; $display("FAIL clr_len2: got %0d required %0d", n, DEPTH - 2); end
      do_reset();
      checks++;
      if (bus.ovr !== 1'b0) begin errors++; $display("FAIL ovr_rst: got %b required 0", bus.ovr); end
      set_cfg(1'b0, 16'd0, '0, '0, 8'd0, 8'd0);
      din = 24'h13579B;
      vld = 1'b1;
      model_step(24'h13579B, eo);
      @(negedge clk);
      din = 24'h2468AC;
      @(negedge clk);
      din = 24'h777777;
      @(negedge clk);
      vld = 1'b0;
      pulses = 0;
      first = 0;
      seen = '0;
      for (int k = 3; k < 15; k++) begin
         if (bus.vld_o) begin
            pulses++;
            if (first == 0) begin
               first = k;
               seen = bus.data_o;
            end
         end
         @(negedge clk);
      end
      checks += 4;
      if (pulses !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d required 1", pulses); end
      if (first !== 5) begin errors++; $display("FAIL ovr_latency: got %0d required 5", first); end
      if (seen !== 24'h13579B) begin errors++; $display("FAIL bypass_data: got %h required 13579b", seen); end
      if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", bus.ovr); end
      run_sample(24'h000042, got);
      checks++;
      if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b required 1", bus.ovr); end
   endtask

   task automatic test_random_wrap();
      logic [DW-1:0] got;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         set_cfg(($urandom_range(0, 7) != 0), 16'h1000, (AW+FW)'($urandom_range(0, 2047)),
                 AW'(6), 8'($urandom), 8'($urandom));
         run_sample(DW'($urandom), got);
      end
      for (int i = 0; i < 200; i++) begin
         set_cfg(($urandom_range(0, 7) != 0), 16'($urandom_range(16'hC000, 16'hFFFF)),
                 (AW+FW)'($urandom_range(0, 2047)), AW'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom));
         run_sample(DW'($urandom), got);
      end
   endtask

   task automatic test_async_reset();
      int n, pulses;
      logic [DW-1:0] got;
      set_cfg(1'b0, 16'd0, '0, '0, 8'd0, 8'd0);
      run_sample(24'h123456, got);
      set_cfg(1'b1, 16'd0, (AW+FW)'(256), '0, 8'd64, 8'd128);
      din = 24'h654321;
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks += 3;
      if (bus.data_o !== '0) begin errors++; $display("FAIL mid_rst_data: got %h required 0", bus.data_o); end
      if (bus.vld_o !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %b required 0", bus.vld_o); end
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %b required 1", bus.busy); end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      pulses = 0;
      while (bus.busy && n < 4 * DEPTH) begin
         @(negedge clk);
         if (bus.vld_o) pulses++;
         n++;
      end
      checks += 2;
      if (pulses !== 0) begin errors++; $display("FAIL mid_rst_pulse: got %0d required 0", pulses); end
      if (n !== DEPTH) begin errors++; $display("FAIL mid_rst_clr: got %0d required %0d", n, DEPTH); end
      set_cfg(1'b1, 16'd0, (AW+FW)'(512), '0, 8'd0, 8'd255);
      for (int i = 0; i < 4; i++) run_sample(DW'($urandom), got);
   endtask

   initial begin
      test_reset();
      test_reset_clear();
      test_fixed_delay();
      test_fractional();
      test_feedback_sat();
      test_overrun_bypass();
      test_random_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
